// File: rtl/huff_seq_ctrl.sv
// huff_seq_ctrl -- sequencing controller for a block Huffman encoder.
//
// Collects NSYM 8-bit symbols into a packed buffer. It then steps the
// frequency stage, the bitmap/tree stage and the code-table stage in that
// order, and signals completion with a one-cycle done pulse.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 begin a block (honoured only in IDLE, or in ERR)
//   sym_valid, sym_data   symbol input stream; sym_ready is high in LOAD
//   buffer_data           packed symbols, symbol k in bits [8k+7:8k]
//   freq_start/freq_done  pulse/handshake with the frequency stage
//   bitmap_start/_done    pulse/handshake with the bitmap/tree stage
//   code_enable           level enable for CODE_CYCLES cycles
//   busy, done, err       status; state exposes the FSM encoding
//
// Build option: define HUFF_SEQ_CTRL_TIMEOUT_EN to add a watchdog on the
// FREQ/BMAP waits. When the watchdog expires, the FSM moves to ERR. Without
// the option, ERR cannot be reached and err stays 0.
module huff_seq_ctrl #(
  parameter int NSYM        = 20,
  parameter int CODE_CYCLES = 48,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sym_valid,
  input  logic [7:0]        sym_data,
  output logic              sym_ready,
  output logic [8*NSYM-1:0] buffer_data,
  output logic              freq_start,
  input  logic              freq_done,
  output logic              bitmap_start,
  input  logic              bitmap_done,
  output logic              code_enable,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FREQ = 3'd2;
  localparam logic [2:0] S_BMAP = 3'd3;
  localparam logic [2:0] S_CODE = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam int CW  = $clog2(NSYM + 1);
  localparam int CCW = $clog2(CODE_CYCLES + 1);

  logic [CW-1:0]  cnt;
  logic [CCW-1:0] code_cnt;
  logic [2:0]     nxt;

`ifdef HUFF_SEQ_CTRL_TIMEOUT_EN
  logic [7:0] wdog;
  logic       wd_hit;
  // wdog holds the number of cycles already spent in this state. It equals
  // TIMEOUT-1 during the TIMEOUT-th cycle.
  assign wd_hit = (wdog == 8'(TIMEOUT - 1));
`else
  assign err = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = S_LOAD;
      S_LOAD: if (sym_valid && cnt == CW'(NSYM - 1)) nxt = S_FREQ;
      // The *_start pulse is still high in the first cycle of FREQ/BMAP.
      // A done input seen in that same cycle is ignored.
      S_FREQ: begin
        if (!freq_start && freq_done) nxt = S_BMAP;
`ifdef HUFF_SEQ_CTRL_TIMEOUT_EN
        else if (wd_hit) nxt = S_ERR;
`endif
      end
      S_BMAP: begin
        if (!bitmap_start && bitmap_done) nxt = S_CODE;
`ifdef HUFF_SEQ_CTRL_TIMEOUT_EN
        else if (wd_hit) nxt = S_ERR;
`endif
      end
      S_CODE: if (code_cnt == CCW'(CODE_CYCLES - 1)) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
`ifdef HUFF_SEQ_CTRL_TIMEOUT_EN
      S_ERR:  if (start) nxt = S_IDLE;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // Every output is registered. Each one is decoded from the next state, so
  // it lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      code_cnt     <= '0;
      buffer_data  <= '0;
      sym_ready    <= 1'b0;
      freq_start   <= 1'b0;
      bitmap_start <= 1'b0;
      code_enable  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef HUFF_SEQ_CTRL_TIMEOUT_EN
      wdog         <= '0;
      err          <= 1'b0;
`endif
    end else begin
      state        <= nxt;
      sym_ready    <= (nxt == S_LOAD);
      freq_start   <= (nxt == S_FREQ) && (state != S_FREQ);
      bitmap_start <= (nxt == S_BMAP) && (state != S_BMAP);
      code_enable  <= (nxt == S_CODE);
      busy         <= (nxt != S_IDLE);
      done         <= (nxt == S_DONE);

      if (state == S_IDLE && start) begin
        cnt         <= '0;
        buffer_data <= '0;
      end else if (state == S_LOAD && sym_valid) begin
        for (int k = 0; k < NSYM; k++)
          if (cnt == CW'(k)) buffer_data[8*k +: 8] <= sym_data;
        cnt <= cnt + 1'b1;
      end

      code_cnt <= (state == S_CODE) ? code_cnt + 1'b1 : '0;

`ifdef HUFF_SEQ_CTRL_TIMEOUT_EN
      if (nxt != state)
        wdog <= '0;
      else if (state == S_FREQ || state == S_BMAP)
        wdog <= wdog + 8'd1;
      else
        wdog <= '0;
      err <= (nxt == S_ERR);
`endif
    end
  end

endmodule

// File: tb/tb_huff_seq_ctrl.sv
// Directed testbench for huff_seq_ctrl. Inputs are driven and outputs are
// sampled 1 time unit after each rising edge.
module tb_huff_seq_ctrl;
  localparam int NSYM = 20;
  localparam int CC   = 48;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               sym_valid = 1'b0;
  logic [7:0]         sym_data = 8'h00;
  logic               sym_ready;
  logic [8*NSYM-1:0]  buffer_data;
  logic               freq_start, bitmap_start, code_enable;
  logic               freq_done = 1'b0, bitmap_done = 1'b0;
  logic               busy, done, err;
  logic [2:0]         state;

  int errors = 0;
  int checks = 0;
  int fs_n = 0, bs_n = 0, ce_n = 0, dn_n = 0;

  huff_seq_ctrl #(.NSYM(NSYM), .CODE_CYCLES(CC), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .start(start),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .buffer_data(buffer_data),
    .freq_start(freq_start), .freq_done(freq_done),
    .bitmap_start(bitmap_start), .bitmap_done(bitmap_done),
    .code_enable(code_enable), .busy(busy), .done(done), .err(err),
    .state(state)
  );

  always #5 clk = ~clk;

  // Count strobe activity on the falling edge.
  always @(negedge clk) begin
    if (freq_start)   fs_n <= fs_n + 1;
    if (bitmap_start) bs_n <= bs_n + 1;
    if (code_enable)  ce_n <= ce_n + 1;
    if (done)         dn_n <= dn_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] exp_buf(input logic [7:0] base);
    logic [159:0] b;
    b = '0;
    for (int k = 0; k < NSYM; k++) b[8*k +: 8] = base + 8'(k);
    return b;
  endfunction

  // start, then NSYM symbols with sym_valid held. freq_start must appear
  // exactly NSYM ticks after the start tick.
  task automatic load_block(input logic [7:0] base);
    start = 1'b1;
    tick();
    chk("load_entry_state", 160'(state), 160'(1));
    chk("load_entry_ready", 160'(sym_ready), 160'(1));
    start = 1'b0;
    sym_valid = 1'b1;
    for (int k = 0; k < NSYM; k++) begin
      sym_data = base + 8'(k);
      tick();
      if (k < NSYM - 1) chk("load_state", 160'(state), 160'(1));
    end
    sym_valid = 1'b0;
    chk("freq_entry_state", 160'(state), 160'(2));
    chk("freq_start_pulse", 160'(freq_start), 160'(1));
    chk("ready_low_after_load", 160'(sym_ready), 160'(0));
  endtask

  // Called in the freq_start cycle. Each done input is raised d ticks after
  // the corresponding start pulse.
  task automatic handshake(input int d);
    repeat (d) tick();
    freq_done = 1'b1;
    tick();
    freq_done = 1'b0;
    chk("bmap_entry_state", 160'(state), 160'(3));
    chk("bitmap_start_pulse", 160'(bitmap_start), 160'(1));
    repeat (d) tick();
    bitmap_done = 1'b1;
    tick();
    bitmap_done = 1'b0;
    chk("code_entry_state", 160'(state), 160'(4));
    chk("code_enable_on", 160'(code_enable), 160'(1));
  endtask

  task automatic wait_done(output int t);
    t = 0;
    while (done !== 1'b1 && t < 300) begin
      tick();
      t++;
    end
  endtask

  initial begin
    int t, k, i, f0, b0, c0, d0;

    // Reset
    repeat (3) tick();
    chk("rst_state", 160'(state), 160'(0));
    chk("rst_buffer", buffer_data, 160'(0));
    chk("rst_ready", 160'(sym_ready), 160'(0));
    chk("rst_strobes", 160'({freq_start, bitmap_start, code_enable, done}), 160'(0));
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_err", 160'(err), 160'(0));
    reset = 1'b0;
    tick();
    chk("idle_hold", 160'(state), 160'(0));

    // Full block, symbols 0x00..0x13, done inputs after 3 cycles
    f0 = fs_n; b0 = bs_n; c0 = ce_n; d0 = dn_n;
    load_block(8'h00);
    chk("busy_freq", 160'(busy), 160'(1));
    chk("buf_lo", 160'(buffer_data[7:0]), 160'(8'h00));
    chk("buf_hi", 160'(buffer_data[159:152]), 160'(8'h13));
    chk("buf_full", buffer_data, exp_buf(8'h00));
    handshake(3);
    wait_done(t);
    chk("code_len", 160'(t), 160'(CC));
    chk("done_state", 160'(state), 160'(5));
    tick();
    chk("after_done_state", 160'(state), 160'(0));
    chk("after_done_pulse", 160'(done), 160'(0));
    chk("after_done_busy", 160'(busy), 160'(0));
    chk("cnt_freq_start", 160'(fs_n - f0), 160'(1));
    chk("cnt_bitmap_start", 160'(bs_n - b0), 160'(1));
    chk("cnt_code_enable", 160'(ce_n - c0), 160'(CC));
    chk("cnt_done", 160'(dn_n - d0), 160'(1));
    chk("buf_held_idle", buffer_data, exp_buf(8'h00));

    // Toggled sym_valid: idle cycles carry junk data that must not be written
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("buf_cleared", buffer_data, 160'(0));
    k = 0; i = 0;
    while (k < NSYM && i < 60) begin
      sym_valid = (i % 2 == 0);
      sym_data  = sym_valid ? 8'hA0 + 8'(k) : 8'hEE;
      tick();
      if (sym_valid) k++;
      i++;
    end
    sym_valid = 1'b0;
    chk("toggle_cycles", 160'(i), 160'(39));
    chk("toggle_state", 160'(state), 160'(2));
    chk("toggle_buf", buffer_data, exp_buf(8'hA0));

    // freq_done held from the pulse cycle; start and sym_valid in FREQ ignored
    freq_done = 1'b1;
    start = 1'b1;
    sym_valid = 1'b1;
    sym_data = 8'h55;
    tick();
    start = 1'b0;
    sym_valid = 1'b0;
    chk("freq_no_early_exit", 160'(state), 160'(2));
    chk("freq_start_once", 160'(freq_start), 160'(0));
    chk("freq_ready_low", 160'(sym_ready), 160'(0));
    chk("freq_buf_unchanged", buffer_data, exp_buf(8'hA0));
    tick();
    freq_done = 1'b0;
    chk("freq_exit_next", 160'(state), 160'(3));
    bitmap_done = 1'b1;
    tick();
    chk("bmap_no_early_exit", 160'(state), 160'(3));
    tick();
    bitmap_done = 1'b0;
    chk("bmap_exit_next", 160'(state), 160'(4));
    // start in CODE ignored; CODE length unaffected
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("code_start_ign_state", 160'(state), 160'(4));
    chk("code_start_ign_ce", 160'(code_enable), 160'(1));
    chk("code_start_ign_done", 160'(done), 160'(0));
    wait_done(t);
    chk("code_len_2", 160'(t), 160'(CC - 1));
    tick();

    // reset in CODE cycle 10
    load_block(8'h40);
    handshake(1);
    repeat (9) tick();
    chk("code_c10", 160'(code_enable), 160'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midcode_rst_state", 160'(state), 160'(0));
    chk("midcode_rst_ce", 160'(code_enable), 160'(0));
    chk("midcode_rst_busy", 160'(busy), 160'(0));
    tick();
    load_block(8'h80);
    handshake(1);
    wait_done(t);
    chk("post_rst_code_len", 160'(t), 160'(CC));
    chk("post_rst_buf", buffer_data, exp_buf(8'h80));
    tick();
    chk("post_rst_idle", 160'(state), 160'(0));

`ifdef HUFF_SEQ_CTRL_TIMEOUT_EN
    // Watchdog: bitmap_done never comes
    load_block(8'h10);
    tick();
    freq_done = 1'b1;
    tick();
    freq_done = 1'b0;
    repeat (254) tick();
    chk("wd_bmap_255", 160'(state), 160'(3));
    tick();
    chk("wd_err_state", 160'(state), 160'(6));
    chk("wd_err_flag", 160'(err), 160'(1));
    chk("wd_err_busy", 160'(busy), 160'(1));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wd_clear_state", 160'(state), 160'(0));
    chk("wd_clear_err", 160'(err), 160'(0));
`else
    chk("err_tied_low", 160'(err), 160'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
